// File: rtl/iref_setup_pkg.sv
// Shared definitions for the reference-current setup controller.
//   state_t        : FSM state encoding (also exported on the debug port)
//   BUS_WIDTH_DEF  : default width of the reference-current code
package iref_setup_pkg;

  localparam int BUS_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_EVAL   = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

endpackage

// File: rtl/iref_setup_ctrl_settle_timer.sv
// settle_timer: loadable down-counter used to hold each DAC code stable
// before the comparator is sampled.
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   load        : load count with load_value (wins over dec)
//   dec         : decrement by one; saturates at zero
//   load_value  : reload value
//   zero        : count is zero
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iref_setup_ctrl.sv
// iref_setup_ctrl: sweeps a reference-current DAC code downward from full
// scale until the comparator reports the current is no longer above target.
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse; begins a sweep from IDLE, DONE or FAIL
//   abort        : level; returns to IDLE from any state (below rst only)
//   comp_hi      : comparator, 1 = measured current above target
//   i_ref_setup  : registered DAC code
//   completed    : registered; final code found and held
//   busy         : registered; high in LOAD, SETTLE, EVAL
//   fail         : registered; code reached zero without the comparator tripping
//   fsm_state    : registered FSM state, for observation
// Handshake: start is a single-cycle request that is only accepted in IDLE,
// DONE or FAIL; while busy=1 it is dropped with no effect.
module iref_setup_ctrl
  import iref_setup_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 comp_hi,
  output logic [BUS_WIDTH-1:0] i_ref_setup,
  output logic                 completed,
  output logic                 busy,
  output logic                 fail,
  output logic [2:0]           fsm_state
);

  // SETTLE_CYCLES-1 is the largest value the timer ever holds.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     RELOAD    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] CODE_MAX  = '1;
  localparam logic [BUS_WIDTH-1:0] STEP_CODE = BUS_WIDTH'(STEP);

  state_t state;
  logic   timer_load;
  logic   timer_dec;
  logic   timer_zero;
  logic   can_step;

  assign can_step = (i_ref_setup >= STEP_CODE);

  // Timer is reloaded on entry to every SETTLE phase; abort freezes it.
  assign timer_load = !abort && ((state == S_LOAD) ||
                                 ((state == S_EVAL) && comp_hi && can_step));
  assign timer_dec  = !abort && (state == S_SETTLE) && !timer_zero;

  settle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (RELOAD),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      i_ref_setup <= CODE_MAX;
      completed   <= 1'b0;
      busy        <= 1'b0;
      fail        <= 1'b0;
    end else if (abort) begin
      // Code is deliberately left where the sweep stopped.
      state     <= S_IDLE;
      completed <= 1'b0;
      busy      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          i_ref_setup <= CODE_MAX;
          state       <= S_SETTLE;
        end
        S_SETTLE: begin
          if (timer_zero) state <= S_EVAL;
        end
        S_EVAL: begin
          if (!comp_hi) begin
            state     <= S_DONE;
            completed <= 1'b1;
            busy      <= 1'b0;
          end else if (can_step) begin
            i_ref_setup <= i_ref_setup - STEP_CODE;
            state       <= S_SETTLE;
          end else begin
            // Clamp at zero instead of wrapping to full scale.
            i_ref_setup <= '0;
            fail        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_FAIL;
          end
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            completed <= 1'b0;
            fail      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_iref_setup_ctrl.sv
module tb_iref_setup_ctrl;
  import iref_setup_pkg::*;

  localparam int MAXC   = 1023;
  localparam int SETTLE = 4;
  localparam int BOUND  = 20000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus controls ----------------
  int   thr       = 5000;  // comparator threshold: comp_hi = code > thr
  int   sel       = 0;     // 0: STEP=1 instance, 1: STEP=3 instance
  logic start_drv = 1'b0;
  logic abort     = 1'b0;
  logic spam_eval = 1'b0;  // pulse start in every EVAL cycle

  // ---------------- DUT 0 (defaults) ----------------
  logic       start0, comp0, completed0, busy0, fail0;
  logic [9:0] code0;
  logic [2:0] st0;

  // ---------------- DUT 1 (STEP = 3) ----------------
  logic       start1, comp1, completed1, busy1, fail1;
  logic [9:0] code1;
  logic [2:0] st1;

  assign comp0  = int'(code0) > thr;
  assign comp1  = int'(code1) > thr;
  assign start0 = (start_drv && sel == 0) || (spam_eval && st0 == S_EVAL);
  assign start1 = start_drv && sel == 1;

  iref_setup_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .comp_hi(comp0),
    .i_ref_setup(code0), .completed(completed0), .busy(busy0), .fail(fail0),
    .fsm_state(st0)
  );

  iref_setup_ctrl #(.BUS_WIDTH(10), .STEP(3), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .comp_hi(comp1),
    .i_ref_setup(code1), .completed(completed1), .busy(busy1), .fail(fail1),
    .fsm_state(st1)
  );

  // Observation mux for the shared sweep task.
  logic [9:0] o_code;
  logic       o_completed, o_busy, o_fail;
  always_comb begin
    o_code      = (sel == 1) ? code1 : code0;
    o_completed = (sel == 1) ? completed1 : completed0;
    o_busy      = (sel == 1) ? busy1 : busy0;
    o_fail      = (sel == 1) ? fail1 : fail0;
  end

  // completed and fail are mutually exclusive at all times.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((completed0 && fail0) || (completed1 && fail1)) begin
        errors++;
        $display("FAIL flags_exclusive: completed0=%0b fail0=%0b completed1=%0b fail1=%0b required not both 1",
                 completed0, fail0, completed1, fail1);
      end
    end
  end

  // ---------------- reference model ----------------
  // Codes visited are MAXC - k*step for k = 0,1,...; the sweep ends at the
  // first code not above thr. Each code costs SETTLE+1 cycles after the
  // single LOAD cycle. If the sequence would go negative, the sweep fails
  // after visiting every non-negative code.
  function automatic void model(input int step, input int t, output int exp_code,
                                output int exp_cycles, output bit exp_fail);
    int k;
    k = (t >= MAXC) ? 0 : (MAXC - t + step - 1) / step;
    if (MAXC - k * step >= 0) begin
      exp_code   = MAXC - k * step;
      exp_cycles = 1 + (k + 1) * (SETTLE + 1);
      exp_fail   = 1'b0;
    end else begin
      exp_code   = 0;
      exp_cycles = 1 + (MAXC / step + 1) * (SETTLE + 1);
      exp_fail   = 1'b1;
    end
  endfunction

  // ---------------- driver / scenario tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
  endtask

  // Full sweep on the selected instance, checked against the model.
  task automatic sweep(input int s, input int t, input logic spam, input string name);
    int ec, ecy, n, prev;
    bit ef;
    bit went_up;
    model((s == 1) ? 3 : 1, t, ec, ecy, ef);
    @(negedge clk);
    sel = s;
    thr = t;
    spam_eval = spam;
    pulse_start();
    n = 0;
    went_up = 1'b0;
    prev = MAXC + 1;
    while (!(o_completed || o_fail) && n < BOUND) begin
      @(posedge clk);
      n++;
      #1;
      if (int'(o_code) > prev) went_up = 1'b1;
      prev = int'(o_code);
    end
    spam_eval = 1'b0;
    checks++;
    if (n !== ecy) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d (thr=%0d)", name, n, ecy, t);
    end
    checks++;
    if (int'(o_code) !== ec) begin
      errors++;
      $display("FAIL %s_code: got %0d, expected %0d (thr=%0d)", name, o_code, ec, t);
    end
    checks++;
    if (o_completed !== !ef || o_fail !== ef || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: got completed=%0b fail=%0b busy=%0b, expected %0b %0b 0",
               name, o_completed, o_fail, o_busy, !ef, ef);
    end
    checks++;
    if (went_up) begin
      errors++;
      $display("FAIL %s_monotonic: code rose during sweep, got final %0d expected non-increasing", name, o_code);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (code0 !== 10'd1023 || completed0 !== 1'b0 || busy0 !== 1'b0 ||
        fail0 !== 1'b0 || st0 !== 3'(S_IDLE)) begin
      errors++;
      $display("FAIL reset_dut0: got code=%0d c=%0b b=%0b f=%0b st=%0d, expected 1023 0 0 0 0",
               code0, completed0, busy0, fail0, st0);
    end
    checks++;
    if (code1 !== 10'd1023 || completed1 !== 1'b0 || busy1 !== 1'b0 || fail1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: got code=%0d c=%0b b=%0b f=%0b, expected 1023 0 0 0",
               code1, completed1, busy1, fail1);
    end
    // The first start after reset release is accepted immediately.
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    thr = 5000;
    pulse_start();
    checks++;
    if (busy0 !== 1'b1 || st0 !== 3'(S_LOAD)) begin
      errors++;
      $display("FAIL first_start: got busy=%0b st=%0d, expected 1 %0d", busy0, st0, S_LOAD);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_threshold();
    sweep(0, 700, 1'b0, "thr700");
  endtask

  task automatic test_comp_low();
    sweep(0, 5000, 1'b0, "comp_lo");
  endtask

  task automatic test_fail_no_wrap();
    sweep(1, -1, 1'b0, "nowrap");
  endtask

  task automatic test_start_while_busy();
    sweep(0, 700, 1'b1, "busy_start");
    // Restart from DONE: flags clear on the accepting edge, code reloads next.
    pulse_start();
    checks++;
    if (completed0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_flags: got completed=%0b busy=%0b, expected 0 1", completed0, busy0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (code0 !== 10'd1023) begin
      errors++;
      $display("FAIL restart_code: got %0d, expected 1023", code0);
    end
    // Let this sweep finish cleanly (threshold still 700).
    for (int i = 0; i < BOUND && !completed0; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int n;
    @(negedge clk);
    sel = 0;
    thr = -1;
    pulse_start();
    n = 0;
    while (code0 !== 10'd900 && n < BOUND) begin
      @(posedge clk);
      n++;
      #1;
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (st0 !== 3'(S_IDLE) || code0 !== 10'd900 || busy0 !== 1'b0 ||
        completed0 !== 1'b0 || fail0 !== 1'b0) begin
      errors++;
      $display("FAIL abort: got st=%0d code=%0d busy=%0b c=%0b f=%0b, expected 0 900 0 0 0",
               st0, code0, busy0, completed0, fail0);
    end
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (st0 !== 3'(S_IDLE) || code0 !== 10'd900) begin
      errors++;
      $display("FAIL idle_hold: got st=%0d code=%0d, expected 0 900", st0, code0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    sel = 0;
    thr = -1;
    pulse_start();
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (st0 !== 3'(S_IDLE) || code0 !== 10'd1023 || busy0 !== 1'b0 ||
        completed0 !== 1'b0 || fail0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got st=%0d code=%0d busy=%0b c=%0b f=%0b, expected 0 1023 0 0 0",
               st0, code0, busy0, completed0, fail0);
    end
    @(negedge clk);
    rst = 1'b0;
    start_drv = 1'b0;
    thr = 5000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 5; i++) begin
      t = int'($urandom_range(600, 1030));
      sweep(0, t, logic'($urandom_range(0, 1)), "rand_s1");
    end
    for (int i = 0; i < 3; i++) begin
      t = int'($urandom_range(400, 1023));
      sweep(1, t, 1'b0, "rand_s3");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_comp_low();
    test_threshold();
    test_fail_no_wrap();
    test_start_while_busy();
    test_abort();
    test_reset_mid_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
